// File: rtl/xor_cipher_pkg.sv
// Shared types and defaults for the XOR cipher front end: loader state encoding
// and default key/message sizes.
package xor_cipher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KEY  = 2'd1,
      MSG  = 2'd2,
      DONE = 2'd3
   } loader_state_t;

   localparam int DEF_KEY_SIZE = 32;
   localparam int DEF_MSG_SIZE = 512;

   function automatic int bytes_of(input int bits);
      return bits / 8;
   endfunction

endpackage

// File: rtl/xor_frame_loader_byte_piso.sv
// byte_piso: 8-bit parallel-load shifter, MSB first, with empty and last-bit flags
// so the loader can refill it on the final bit without a bubble.
module byte_piso
   import xor_cipher_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] din,
   output logic       dout,
   output logic       empty,
   output logic       last_bit
);

   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic       full;

   // A load always wins over the shift, which is what makes back-to-back bytes gapless.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
         full    <= 1'b0;
      end else if (en) begin
         if (load) begin
            shreg   <= din;
            bit_cnt <= 3'd7;
            full    <= 1'b1;
         end else if (full) begin
            shreg <= {shreg[6:0], 1'b0};
            if (bit_cnt == 3'd0) begin
               full <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt - 3'd1;
            end
         end
      end
   end

   assign dout     = full & shreg[7];
   assign empty    = ~full;
   assign last_bit = full & (bit_cnt == 3'd0);

endmodule

// File: rtl/xor_frame_loader.sv
// Byte-wide front end for the XOR cipher serial load port: key bytes then message bytes,
// shifted MSB first with load_key/load_msg framing. Optional checksum: XOR_LOADER_CKSUM_EN.
module xor_frame_loader
   import xor_cipher_pkg::*;
#(
   parameter int KEY_SIZE = DEF_KEY_SIZE,
   parameter int MSG_SIZE = DEF_MSG_SIZE
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iEn,
   input  logic       iStart,
   input  logic [7:0] iByte,
   input  logic       iByte_valid,
   output logic       oByte_ready,
   output logic       oSerial_data,
   output logic       oLoad_key,
   output logic       oLoad_msg,
   output logic       oBusy,
   output logic       oDone
`ifdef XOR_LOADER_CKSUM_EN
   ,
   output logic [7:0] oChecksum
`endif
);

   localparam int KEY_BYTES = bytes_of(KEY_SIZE);
   localparam int MSG_BYTES = bytes_of(MSG_SIZE);
   localparam int CNT_W     = $clog2(MSG_BYTES) + 1;
   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES);
   localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BYTES);

   loader_state_t    state;
   loader_state_t    state_next;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W-1:0] phase_total;
   logic             more_bytes;
   logic             phase_end;
   logic             byte_ready;
   logic             accept;
   logic             serial_bit;
   logic             empty;
   logic             last_bit;

   // byte_cnt counts bytes accepted in the current phase; the phase ends once the
   // final byte is on its last bit, so the shifter is always empty on phase entry.
   assign phase_total = (state == KEY) ? KEY_LAST : MSG_LAST;
   assign more_bytes  = (byte_cnt < phase_total);
   assign phase_end   = last_bit & ~more_bytes;
   assign accept      = byte_ready & iByte_valid;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
      end else if (iEn) begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) state_next = KEY;
         end
         KEY: begin
            byte_ready = iEn & more_bytes & (empty | last_bit);
            if (phase_end) state_next = MSG;
         end
         MSG: begin
            byte_ready = iEn & more_bytes & (empty | last_bit);
            if (phase_end) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         byte_cnt <= '0;
      end else if (iEn) begin
         if (state_next != state) begin
            byte_cnt <= '0;
         end else if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
         end
      end
   end

   byte_piso u_piso (
      .clk      (iClk),
      .rst      (iRst),
      .en       (iEn),
      .load     (accept),
      .din      (iByte),
      .dout     (serial_bit),
      .empty    (empty),
      .last_bit (last_bit)
   );

   assign oByte_ready  = byte_ready;
   assign oSerial_data = serial_bit;
   assign oLoad_key    = (state == KEY) & ~empty;
   assign oLoad_msg    = (state == MSG) & ~empty;
   assign oBusy        = (state != IDLE);
   assign oDone        = (state == DONE);

`ifdef XOR_LOADER_CKSUM_EN
   logic [7:0] checksum;

   // Accumulates across the whole frame and simply holds once the frame ends.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         checksum <= '0;
      end else if (iEn) begin
         if ((state == IDLE) && iStart) begin
            checksum <= '0;
         end else if (accept) begin
            checksum <= checksum ^ iByte;
         end
      end
   end

   assign oChecksum = checksum;
`endif

endmodule

// File: tb/tb_xor_frame_loader.sv
// Directed bench for xor_frame_loader: key DE AD BE EF plus message bytes 00..3F,
// exercising back-to-back flow, valid gaps, enable freeze and reset mid-frame.
module tb_xor_frame_loader;

   localparam int FRAME_BYTES = 68;
   localparam int MAX_CYC     = 600;

   logic       iClk = 1'b0;
   logic       iRst;
   logic       iEn;
   logic       iStart;
   logic [7:0] iByte;
   logic       iByte_valid;
   logic       oByte_ready;
   logic       oSerial_data;
   logic       oLoad_key;
   logic       oLoad_msg;
   logic       oBusy;
   logic       oDone;
`ifdef XOR_LOADER_CKSUM_EN
   logic [7:0] oChecksum;
`endif

   int checks = 0;
   int passes = 0;

   logic obs_ser  [0:MAX_CYC-1];
   logic obs_key  [0:MAX_CYC-1];
   logic obs_msg  [0:MAX_CYC-1];
   logic obs_rdy  [0:MAX_CYC-1];
   logic obs_busy [0:MAX_CYC-1];
   logic obs_done [0:MAX_CYC-1];
   logic obs_en   [0:MAX_CYC-1];

   xor_frame_loader dut (
      .iClk         (iClk),
      .iRst         (iRst),
      .iEn          (iEn),
      .iStart       (iStart),
      .iByte        (iByte),
      .iByte_valid  (iByte_valid),
      .oByte_ready  (oByte_ready),
      .oSerial_data (oSerial_data),
      .oLoad_key    (oLoad_key),
      .oLoad_msg    (oLoad_msg),
      .oBusy        (oBusy),
      .oDone        (oDone)
`ifdef XOR_LOADER_CKSUM_EN
      ,
      .oChecksum    (oChecksum)
`endif
   );

   always #5 iClk = ~iClk;

   function automatic logic [7:0] frame_byte(input int i);
      case (i)
         0:       return 8'hDE;
         1:       return 8'hAD;
         2:       return 8'hBE;
         3:       return 8'hEF;
         default: return 8'(i - 4);
      endcase
   endfunction

   function automatic logic exp_bit(input int k);
      logic [7:0] b;
      b = frame_byte(k / 8);
      return b[7 - (k % 8)];
   endfunction

   // Runs n cycles starting with iStart on cycle 0, feeding the frame whenever ready.
   // Optional valid gap, enable-low window and one-cycle reset (pass -1 to disable).
   task automatic run_frame(input int n, input int gap_at, input int gap_len,
                            input int frz_at, input int frz_len, input int rst_at);
      int idx;
      idx = 0;
      for (int c = 0; c < n; c++) begin
         iStart      = (c == 0);
         iRst        = (c == rst_at);
         iEn         = !(c >= frz_at && c < frz_at + frz_len);
         iByte_valid = (idx < FRAME_BYTES) && !(c >= gap_at && c < gap_at + gap_len);
         iByte       = frame_byte(idx);
         @(negedge iClk);
         obs_ser[c]  = oSerial_data;
         obs_key[c]  = oLoad_key;
         obs_msg[c]  = oLoad_msg;
         obs_rdy[c]  = oByte_ready;
         obs_busy[c] = oBusy;
         obs_done[c] = oDone;
         obs_en[c]   = iEn;
         if (iByte_valid && oByte_ready) idx++;
         @(posedge iClk);
         #1;
      end
      iStart      = 1'b0;
      iRst        = 1'b0;
      iEn         = 1'b1;
      iByte_valid = 1'b0;
   endtask

   task automatic test_reset();
      iRst = 1'b1; iEn = 1'b1; iStart = 1'b0; iByte = 8'h5A; iByte_valid = 1'b1;
      repeat (2) begin
         @(posedge iClk);
         #1;
      end
      @(negedge iClk);
      checks++;
      if ({oByte_ready, oSerial_data, oLoad_key, oLoad_msg, oBusy, oDone} !== 6'b0)
         $display("[TB] FAIL reset_outputs: got %b, required 000000",
                  {oByte_ready, oSerial_data, oLoad_key, oLoad_msg, oBusy, oDone});
      else passes++;
`ifdef XOR_LOADER_CKSUM_EN
      checks++;
      if (oChecksum !== 8'h00) $display("[TB] FAIL reset_checksum: got %h, required 00", oChecksum);
      else passes++;
`endif
      @(posedge iClk);
      #1;
      iRst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge iClk);
         checks++;
         if ({oByte_ready, oBusy} !== 2'b00)
            $display("[TB] FAIL idle_ready: cycle %0d ready/busy %b, required 00", i, {oByte_ready, oBusy});
         else passes++;
         @(posedge iClk);
         #1;
      end
      iByte_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int errs, first, k, ndone;
      logic [7:0] got;
      run_frame(549, -1, 0, -1, 0, -1);

      errs = 0; first = -1;
      for (int c = 0; c < 549; c++)
         if (obs_key[c] !== (c >= 2 && c <= 33)) begin errs++; if (first < 0) first = c; end
      checks++;
      if (errs !== 0) $display("[TB] FAIL key_strobe: %0d wrong cycles, first %0d, required high on 2..33 only", errs, first);
      else passes++;

      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 8; i++) got[7 - i] = obs_ser[2 + 8 * b + i];
         checks++;
         if (got !== frame_byte(b)) $display("[TB] FAIL key_byte%0d: got %h, required %h", b, got, frame_byte(b));
         else passes++;
      end

      errs = 0;
      for (int c = 2; c <= 33; c++) if (obs_ser[c] !== exp_bit(c - 2)) errs++;
      checks++;
      if (errs !== 0) $display("[TB] FAIL key_bits: %0d wrong bits, required 0", errs);
      else passes++;

      checks++;
      if ({obs_rdy[33], obs_key[34], obs_msg[34], obs_ser[34]} !== 4'b0000)
         $display("[TB] FAIL phase_gap: ready@33/key/msg/ser@34 = %b, required 0000",
                  {obs_rdy[33], obs_key[34], obs_msg[34], obs_ser[34]});
      else passes++;

      errs = 0; first = -1;
      for (int c = 0; c < 549; c++)
         if (obs_msg[c] !== (c >= 35 && c <= 546)) begin errs++; if (first < 0) first = c; end
      checks++;
      if (errs !== 0) $display("[TB] FAIL msg_strobe: %0d wrong cycles, first %0d, required high on 35..546 only", errs, first);
      else passes++;

      errs = 0; k = 0;
      for (int c = 35; c <= 546; c++) begin
         if (obs_ser[c] !== exp_bit(32 + k)) errs++;
         k++;
      end
      checks++;
      if (errs !== 0) $display("[TB] FAIL msg_bits: %0d wrong bits, required 0", errs);
      else passes++;

      ndone = 0; errs = 0;
      for (int c = 0; c < 549; c++) begin
         if (obs_done[c] === 1'b1) ndone++;
         if (obs_key[c] === 1'b1 && obs_msg[c] === 1'b1) errs++;
      end
      checks++;
      if (ndone !== 1 || obs_done[547] !== 1'b1)
         $display("[TB] FAIL done_pulse: count %0d done@547 %b, required count 1 at 547", ndone, obs_done[547]);
      else passes++;
      checks++;
      if (errs !== 0) $display("[TB] FAIL strobe_overlap: %0d cycles with both strobes, required 0", errs);
      else passes++;

      checks++;
      if ({obs_busy[0], obs_busy[1], obs_busy[547], obs_busy[548]} !== 4'b0110)
         $display("[TB] FAIL busy_edges: busy@0,1,547,548 = %b, required 0110",
                  {obs_busy[0], obs_busy[1], obs_busy[547], obs_busy[548]});
      else passes++;

`ifdef XOR_LOADER_CKSUM_EN
      @(negedge iClk);
      checks++;
      if (oChecksum !== 8'h22) $display("[TB] FAIL checksum: got %h, required 22", oChecksum);
      else passes++;
      @(posedge iClk);
      #1;
`endif
   endtask

   task automatic test_valid_gap();
      int errs, k;
      run_frame(556, 194, 5, -1, 0, -1);

      checks++;
      if ({obs_msg[194], obs_ser[194], obs_msg[200], obs_ser[200]} !== 4'b1110)
         $display("[TB] FAIL gap_edges: msg/ser@194, msg/ser@200 = %b, required 1110",
                  {obs_msg[194], obs_ser[194], obs_msg[200], obs_ser[200]});
      else passes++;

      errs = 0;
      for (int c = 195; c <= 199; c++) if ({obs_msg[c], obs_key[c], obs_ser[c]} !== 3'b000) errs++;
      checks++;
      if (errs !== 0) $display("[TB] FAIL gap_idle: %0d gap cycles active, required 0", errs);
      else passes++;

      errs = 0; k = 0;
      for (int c = 0; c < 556; c++)
         if (obs_msg[c] === 1'b1) begin
            if (obs_ser[c] !== exp_bit(32 + k)) errs++;
            k++;
         end
      checks++;
      if (errs !== 0 || k !== 512) $display("[TB] FAIL gap_stream: %0d bad bits, %0d msg bits, required 0 and 512", errs, k);
      else passes++;

      checks++;
      if ({obs_done[551], obs_done[552], obs_busy[553]} !== 3'b010)
         $display("[TB] FAIL gap_done: done@551,552 busy@553 = %b, required 010",
                  {obs_done[551], obs_done[552], obs_busy[553]});
      else passes++;
   endtask

   task automatic test_enable_freeze();
      int errs, k;
      run_frame(553, -1, 0, 206, 3, -1);

      checks++;
      if (obs_ser[205] !== 1'b0) $display("[TB] FAIL freeze_before: ser@205 %b, required 0", obs_ser[205]);
      else passes++;

      errs = 0;
      for (int c = 206; c <= 209; c++) if ({obs_ser[c], obs_msg[c], obs_rdy[c]} !== 3'b110) errs++;
      checks++;
      if (errs !== 0) $display("[TB] FAIL freeze_hold: %0d cycles changed in 206..209, required 0", errs);
      else passes++;

      checks++;
      if ({obs_ser[210], obs_msg[210]} !== 2'b01)
         $display("[TB] FAIL freeze_resume: ser/msg@210 = %b, required 01", {obs_ser[210], obs_msg[210]});
      else passes++;

      errs = 0; k = 0;
      for (int c = 0; c < 553; c++)
         if (obs_msg[c] === 1'b1 && obs_en[c] === 1'b1) begin
            if (obs_ser[c] !== exp_bit(32 + k)) errs++;
            k++;
         end
      checks++;
      if (errs !== 0 || k !== 512) $display("[TB] FAIL freeze_stream: %0d bad bits, %0d msg bits, required 0 and 512", errs, k);
      else passes++;

      checks++;
      if ({obs_done[549], obs_done[550], obs_busy[551]} !== 3'b010)
         $display("[TB] FAIL freeze_done: done@549,550 busy@551 = %b, required 010",
                  {obs_done[549], obs_done[550], obs_busy[551]});
      else passes++;
   endtask

   task automatic test_reset_mid_frame();
      int errs, k;
      run_frame(130, -1, 0, -1, 0, 118);

      checks++;
      if (obs_msg[118] !== 1'b1) $display("[TB] FAIL rst_before: msg@118 %b, required 1", obs_msg[118]);
      else passes++;

      errs = 0;
      for (int c = 119; c < 130; c++)
         if ({obs_rdy[c], obs_ser[c], obs_key[c], obs_msg[c], obs_busy[c], obs_done[c]} !== 6'b0) errs++;
      checks++;
      if (errs !== 0) $display("[TB] FAIL rst_abort: %0d cycles with active outputs after reset, required 0", errs);
      else passes++;

`ifdef XOR_LOADER_CKSUM_EN
      @(negedge iClk);
      checks++;
      if (oChecksum !== 8'h00) $display("[TB] FAIL rst_checksum: got %h, required 00", oChecksum);
      else passes++;
      @(posedge iClk);
      #1;
`endif

      run_frame(549, -1, 0, -1, 0, -1);
      errs = 0; k = 0;
      for (int c = 0; c < 549; c++)
         if (obs_msg[c] === 1'b1) begin
            if (obs_ser[c] !== exp_bit(32 + k)) errs++;
            k++;
         end
      checks++;
      if (errs !== 0 || k !== 512) $display("[TB] FAIL fresh_stream: %0d bad bits, %0d msg bits, required 0 and 512", errs, k);
      else passes++;

      checks++;
      if ({obs_done[547], obs_busy[548]} !== 2'b10)
         $display("[TB] FAIL fresh_done: done@547 busy@548 = %b, required 10", {obs_done[547], obs_busy[548]});
      else passes++;

`ifdef XOR_LOADER_CKSUM_EN
      @(negedge iClk);
      checks++;
      if (oChecksum !== 8'h22) $display("[TB] FAIL fresh_checksum: got %h, required 22", oChecksum);
      else passes++;
      @(posedge iClk);
      #1;
`endif
   endtask

   initial begin
      iRst = 1'b1; iEn = 1'b1; iStart = 1'b0; iByte = 8'h00; iByte_valid = 1'b0;
      test_reset();
      test_back_to_back();
      test_valid_gap();
      test_enable_freeze();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
